// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared sizes, load-counter limits and FSM state type for the FC2 classifier stage
package fc_pkg;
   localparam int IN_NUM      = 16;
   localparam int OUT_NUM     = 10;
   localparam int ACC_W       = 29;
   localparam int SCORE_SHIFT = 8;
   localparam int WEIGHT_END  = 160;
   localparam int BIAS_END    = 170;

   localparam logic signed [ACC_W-1:0] SCORE_MAX = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SCORE_MIN = -ACC_W'(32768);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_ARGMAX
   } state_t;
endpackage

// File: rtl/fc2_mac_lane.sv
// rtl/fc2_mac_lane.sv - one class accumulator: bias preload, then signed 16x8 multiply-accumulate
module fc2_mac_lane
   import fc_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    init,
   input  logic                    en,
   input  logic signed [7:0]       bias,
   input  logic signed [15:0]      data,
   input  logic signed [7:0]       weight,
   output logic signed [ACC_W-1:0] acc
);
   logic signed [23:0] prod;

   assign prod = data * weight;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (init) begin
         acc <= {{(ACC_W-8){bias[7]}}, bias} <<< SCORE_SHIFT;
      end else if (en) begin
         acc <= acc + {{(ACC_W-24){prod[23]}}, prod};
      end
   end
endmodule

// File: rtl/fc2_argmax_layer.sv
// rtl/fc2_argmax_layer.sv - FC2 (16->10) MAC stage with sequential argmax
// FC2_SAT_EN: saturate the reported score to 16 bits instead of wrapping.
module fc2_argmax_layer
   import fc_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               weight_valid,
   input  logic [7:0]         filter,
   output logic               weight_done,
   input  logic               i_valid,
   input  logic [255:0]       data_in,
   output logic               o_ready,
   output logic               o_valid,
   output logic [3:0]         o_class,
   output logic signed [15:0] o_score
);
   logic signed [7:0]       w_mem    [WEIGHT_END];
   logic signed [7:0]       bias_mem [OUT_NUM];
   logic [7:0]              load_cnt;
   logic [3:0]              bias_idx;

   state_t                  state;
   logic [3:0]              cnt;
   logic signed [15:0]      act [IN_NUM];
   logic signed [ACC_W-1:0] acc [OUT_NUM];
   logic signed [ACC_W-1:0] best;
   logic [3:0]              best_idx;
   logic signed [ACC_W-1:0] cand_best;
   logic [3:0]              cand_idx;
   logic                    lane_init;
   logic                    lane_en;

   function automatic logic signed [15:0] score_of(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] s;
      s = v >>> SCORE_SHIFT;
`ifdef FC2_SAT_EN
      if (s > SCORE_MAX) return 16'h7fff;
      if (s < SCORE_MIN) return 16'h8000;
      return s[15:0];
`else
      return s[15:0];
`endif
   endfunction

   assign o_ready   = (state == ST_IDLE) && weight_done;
   assign lane_init = (state == ST_IDLE) && i_valid && o_ready;
   assign lane_en   = (state == ST_ACCUM);
   assign bias_idx  = 4'(load_cnt - 8'(WEIGHT_END));

   // Filter stream: weights in class-major order, then one bias per class.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         load_cnt    <= '0;
         weight_done <= 1'b0;
         for (int i = 0; i < WEIGHT_END; i++) w_mem[i] <= '0;
         for (int i = 0; i < OUT_NUM; i++) bias_mem[i] <= '0;
      end else if (weight_valid && !weight_done) begin
         if (load_cnt < 8'(WEIGHT_END)) w_mem[load_cnt] <= filter;
         else bias_mem[bias_idx] <= filter;
         if (load_cnt == 8'(BIAS_END - 1)) weight_done <= 1'b1;
         else load_cnt <= load_cnt + 8'd1;
      end
   end

   for (genvar k = 0; k < OUT_NUM; k++) begin : g_lane
      localparam logic [7:0] BASE = 8'(k * IN_NUM);
      fc2_mac_lane u_lane (
         .clk    (i_clk),
         .rst    (i_rst),
         .init   (lane_init),
         .en     (lane_en),
         .bias   (bias_mem[k]),
         .data   (act[cnt]),
         .weight (w_mem[BASE + {4'd0, cnt}]),
         .acc    (acc[k])
      );
   end

   // Strict greater-than keeps the lower index on ties.
   always_comb begin
      cand_best = best;
      cand_idx  = best_idx;
      if (cnt == 4'd0 || acc[cnt] > best) begin
         cand_best = acc[cnt];
         cand_idx  = cnt;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         best     <= '0;
         best_idx <= '0;
         o_valid  <= 1'b0;
         o_class  <= '0;
         o_score  <= '0;
         for (int j = 0; j < IN_NUM; j++) act[j] <= '0;
      end else begin
         o_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_valid && o_ready) begin
                  for (int j = 0; j < IN_NUM; j++) act[j] <= data_in[16*j +: 16];
                  cnt   <= '0;
                  state <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (cnt == 4'(IN_NUM - 1)) begin
                  cnt   <= '0;
                  state <= ST_ARGMAX;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ST_ARGMAX: begin
               best     <= cand_best;
               best_idx <= cand_idx;
               if (cnt == 4'(OUT_NUM - 1)) begin
                  o_class <= cand_idx;
                  o_score <= score_of(cand_best);
                  o_valid <= 1'b1;
                  cnt     <= '0;
                  state   <= ST_IDLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fc2_argmax_layer.sv
// tb/tb_fc2_argmax_layer.sv - scoreboard bench for fc2_argmax_layer with directed vectors
module tb_fc2_argmax_layer;
   logic               i_clk = 1'b0;
   logic               i_rst = 1'b1;
   logic               weight_valid = 1'b0;
   logic [7:0]         filter = '0;
   logic               weight_done;
   logic               i_valid = 1'b0;
   logic [255:0]       data_in = '0;
   logic               o_ready;
   logic               o_valid;
   logic [3:0]         o_class;
   logic signed [15:0] o_score;

   typedef struct {
      int cls;
      int score;
      int at;
   } exp_t;

   exp_t              sb[$];
   int                cyc = 0;
   int                n_tests = 0;
   int                n_fail = 0;
   logic signed [7:0] wv [160];
   logic signed [7:0] bv [10];

   fc2_argmax_layer dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .weight_valid (weight_valid),
      .filter       (filter),
      .weight_done  (weight_done),
      .i_valid      (i_valid),
      .data_in      (data_in),
      .o_ready      (o_ready),
      .o_valid      (o_valid),
      .o_class      (o_class),
      .o_score      (o_score)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
      end
   endtask

   always @(negedge i_clk) begin
      if (o_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_o_valid: got class %0d score %0d at cycle %0d expected none",
                     o_class, o_score, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("o_class", 32'(o_class), e.cls);
            check("o_score", 32'(o_score), e.score);
            check("latency_cycle", cyc, e.at);
         end
      end
   end

   task automatic set_all(input int w, input int b);
      for (int i = 0; i < 160; i++) wv[i] = 8'(w);
      for (int i = 0; i < 10; i++) bv[i] = 8'(b);
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_valid = 1'b0;
      weight_valid = 1'b0;
      repeat (2) @(negedge i_clk);
      check("rst_o_valid", 32'(o_valid), 0);
      check("rst_o_class", 32'(o_class), 0);
      check("rst_o_score", 32'(o_score), 0);
      check("rst_o_ready", 32'(o_ready), 0);
      check("rst_weight_done", 32'(weight_done), 0);
      i_rst = 1'b0;
      @(negedge i_clk);
   endtask

   task automatic load();
      for (int b = 0; b < 170; b++) begin
         weight_valid = 1'b1;
         filter = (b < 160) ? wv[b] : bv[b-160];
         if (b == 169) check("done_before_last_byte", 32'(weight_done), 0);
         @(negedge i_clk);
      end
      weight_valid = 1'b0;
      check("weight_done", 32'(weight_done), 1);
      check("ready_after_load", 32'(o_ready), 1);
   endtask

   task automatic send(input logic [255:0] d, input int cls, input int score, input bit expect_result);
      exp_t e;
      if (expect_result) check("ready_before_send", 32'(o_ready), 1);
      i_valid = 1'b1;
      data_in = d;
      if (expect_result) begin
         e.cls = cls;
         e.score = score;
         e.at = cyc + 1 + 26;
         sb.push_back(e);
      end
      @(negedge i_clk);
      i_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge i_clk);
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge i_clk);
   endtask

   initial begin
      logic [255:0] d;

      // 1: zero weights, bias k -> highest bias wins; late bytes after done are ignored
      do_reset();
      set_all(0, 0);
      for (int k = 0; k < 10; k++) bv[k] = 8'(k);
      load();
      weight_valid = 1'b1;
      filter = 8'h55;
      @(negedge i_clk);
      weight_valid = 1'b0;
      send({16{16'h1234}}, 9, 9, 1'b1);
      drain();
      check("class_held", 32'(o_class), 9);

      // 6: reset during ARGMAX step 4 kills the result and the weights
      send({16{16'h0100}}, 0, 0, 1'b0);
      repeat (20) @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      check("midrst_o_valid", 32'(o_valid), 0);
      check("midrst_o_class", 32'(o_class), 0);
      check("midrst_o_score", 32'(o_score), 0);
      check("midrst_weight_done", 32'(weight_done), 0);
      check("midrst_o_ready", 32'(o_ready), 0);
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      i_valid = 1'b1;
      repeat (5) @(negedge i_clk);
      check("no_reload_o_ready", 32'(o_ready), 0);
      i_valid = 1'b0;
      repeat (30) @(negedge i_clk);

      // 2: single unit weight on class 3, input 0
      do_reset();
      set_all(0, 0);
      wv[3*16+0] = 8'sd1;
      d = '0;
      d[15:0] = 16'd256;
      load();
      send(d, 3, 1, 1'b1);
      drain();

      // 3: everything zero -> tie resolves to class 0
      do_reset();
      set_all(0, 0);
      load();
      send({16{16'h7abc}}, 0, 0, 1'b1);
      drain();

      // 4: worst-case positive accumulation
      do_reset();
      set_all(127, 0);
      load();
`ifdef FC2_SAT_EN
      send({16{16'h7FFF}}, 0, 32767, 1'b1);
`else
      send({16{16'h7FFF}}, 0, -2056, 1'b1);
`endif
      drain();

      // 5: i_valid before weight_done and mid-ACCUM are dropped
      do_reset();
      i_valid = 1'b1;
      data_in = {16{16'h0001}};
      repeat (3) @(negedge i_clk);
      i_valid = 1'b0;
      set_all(0, 0);
      load();
      send({16{16'h0011}}, 0, 0, 1'b1);
      repeat (4) @(negedge i_clk);
      check("busy_o_ready", 32'(o_ready), 0);
      send({16{16'h2222}}, 0, 0, 1'b0);
      drain();
      repeat (40) @(negedge i_clk);

      // 7: negative weight times negative input beats a positive bias
      do_reset();
      set_all(0, 0);
      wv[5*16+1] = -8'sd1;
      bv[2] = 8'sd1;
      bv[0] = -8'sd3;
      d = '0;
      d[31:16] = 16'hFE00;
      load();
      send(d, 5, 2, 1'b1);
      drain();

      // 8: all-negative tie -> class 0, negative score; back-to-back acceptance
      do_reset();
      set_all(0, -5);
      load();
      send('0, 0, -5, 1'b1);
      for (int i = 0; i < 40 && o_ready !== 1'b1; i++) @(negedge i_clk);
      send({16{16'hffff}}, 0, -5, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
